// File: rtl/gcd_pkg.sv
// Shared types and sizing for the GCD engine and its downstream LCM stage.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } gcd_lcm_state_t;

  localparam int GCD_WIDTH = 32;

  // Bit-step counter width for a WIDTH-step sequential datapath.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/gcd_seq_div.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// Latency: WIDTH cycles after start; done is high in the cycle whose edge retires the last bit.
// Backpressure: none; start is only honoured while idle, results hold until the next start.
module gcd_seq_div
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH:0]   remainder
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // Partial remainder stays below 2*divisor, so WIDTH+1 bits hold it and
  // the extra top bit of the trial difference is the borrow.
  assign shifted = {remainder[WIDTH-1:0], dvd[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dsr};
  assign done    = busy && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      dvd       <= '0;
      dsr       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (!busy) begin
      if (start) begin
        busy      <= 1'b1;
        dvd       <= dividend;
        dsr       <= divisor;
        cnt       <= CW'(WIDTH - 1);
        quotient  <= '0;
        remainder <= '0;
      end
    end else begin
      dvd <= {dvd[WIDTH-2:0], 1'b0};
      if (!trial[WIDTH+1]) begin
        remainder <= trial[WIDTH:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        remainder <= shifted;
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_lcm.sv
// LCM stage after the GCD engine: lcm = (a / gcd) * b via sequential divide then shift-add multiply.
// Latency: out_valid 2*WIDTH+1 cycles after acceptance, 1 cycle when gcd is zero.
// Backpressure: one operation in flight; result held until out_ready, in_ready returns the cycle after.
module gcd_lcm
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] gcd_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] lcm,
  output logic             overflow,
  output logic             div_err
);

  localparam int CW = cnt_width(WIDTH);

  gcd_lcm_state_t     state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_step;
  logic [CW-1:0]      mcnt;

  logic               div_start;
  logic               div_done;
  logic               div_busy_unused;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH:0]     div_rem_unused;

  assign div_start = (state == IDLE) && in_valid && in_ready && (gcd_in != '0);

  gcd_seq_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (a_in),
    .divisor   (gcd_in),
    .busy      (div_busy_unused),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem_unused)
  );

  // Quotient is stable in the divider from the end of DIV until the next start,
  // so the multiplier walks its bits in place instead of copying it.
  assign acc_step = div_quo[mcnt] ? (acc + mcand) : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      lcm       <= '0;
      overflow  <= 1'b0;
      div_err   <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mcnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            acc      <= '0;
            mcand    <= {{WIDTH{1'b0}}, b_in};
            mcnt     <= '0;
            if (gcd_in == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              div_err   <= 1'b1;
              lcm       <= '0;
              overflow  <= 1'b0;
            end else begin
              state <= DIV;
            end
          end
        end
        DIV: begin
          if (div_done) begin
            state <= MUL;
          end
        end
        MUL: begin
          acc   <= acc_step;
          mcand <= {mcand[2*WIDTH-2:0], 1'b0};
          mcnt  <= mcnt + 1'b1;
          if (mcnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            lcm       <= acc_step[WIDTH-1:0];
            overflow  <= |acc_step[2*WIDTH-1:WIDTH];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            lcm       <= '0;
            overflow  <= 1'b0;
            div_err   <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
